// File: rtl/alarm_pkg.sv
// Shared state encoding and key-checker codes for the alarm zone controller.
package alarm_pkg;

  typedef enum logic [2:0] {
    INACTIVO = 3'd0,
    SALIDA   = 3'd1,
    ARMADO   = 3'd2,
    ESPERA   = 3'd3,
    ALARMA   = 3'd4
  } alarm_state_e;

  localparam logic [1:0] KEY_OK    = 2'd0;
  localparam logic [1:0] KEY_OKNEG = 2'd1;
  localparam logic [1:0] KEY_ERROR = 2'd2;
  localparam logic [1:0] NO_KEY    = 2'd3;

endpackage

// File: rtl/alarm_delay_timer.sv
// Loadable down-counter paced by the prescaler tick, used for exit and entry delays.
// expireO flags the tick that takes the count from 1 to 0, so the owner can change
// state on the same edge the count reaches zero.
module alarm_delay_timer #(
  parameter int CNT_W = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] loadVal_i,
  output logic             zero_o,
  output logic             expire_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // A load always wins; otherwise count down one step per tick and park at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = loadVal_i;
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Counter register, cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o   = (count_q == '0);
  assign expire_o = tick_i && (count_q == CNT_W'(1));

endmodule

// File: rtl/alarm_zone_controller.sv
// Multi-zone alarm controller: exit delay after arming, entry delay on delayed zones,
// instant alarm on instant zones, and a wrong-code strike limit while armed.
module alarm_zone_controller
  import alarm_pkg::*;
#(
  parameter int                 N_ZONES     = 4,
  parameter logic [N_ZONES-1:0] DELAY_MASK  = 4'b0010,
  parameter int                 EXIT_TICKS  = 150000,
  parameter int                 ENTRY_TICKS = 150000,
  parameter int                 CNT_W       = 18,
  parameter int                 STRIKES     = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 TICK_EN,
  input  logic [N_ZONES-1:0]   SENSOR_IN,
  input  logic                 KEY_VALID,
  input  logic [1:0]           KEY_CODE,
  output logic [2:0]           STATE_OUT,
  output logic                 SIREN_OUT,
  output logic [N_ZONES-1:0]   ZONE_LATCH,
  output logic [N_ZONES+1:0]   STATUS_MSG
);

  localparam logic [2:0]       STRIKE_MAX = 3'(STRIKES);
  localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_TICKS);
  localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_TICKS);

  logic [N_ZONES-1:0] sync1_q;
  logic [N_ZONES-1:0] sync2_q;
  alarm_state_e       state_q;
  alarm_state_e       state_d;
  logic [2:0]         strikes_q;
  logic [2:0]         strikes_d;
  logic [N_ZONES-1:0] zoneLatch_q;
  logic [N_ZONES-1:0] zoneLatch_d;
  logic               siren_q;
  logic [N_ZONES+1:0] status_q;
  logic [N_ZONES+1:0] status_d;

  logic               timerLoad;
  logic [CNT_W-1:0]   timerLoadVal;
  logic               timerZero;
  logic               timerExpire;

  logic               keyOk;
  logic               keyNeg;
  logic               keyErr;
  logic               instantTrip;
  logic               delayedTrip;
  logic               timedOut;
  logic               strikeLimit;

  alarm_delay_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (CLK),
    .rst      (RST),
    .tick_i   (TICK_EN),
    .load_i   (timerLoad),
    .loadVal_i(timerLoadVal),
    .zero_o   (timerZero),
    .expire_o (timerExpire)
  );

  // Two-flop synchroniser so the FSM only ever sees stable sensor levels.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= SENSOR_IN;
      sync2_q <= sync1_q;
    end
  end

  // Next-state decision; an acting key beats an instant zone, which beats a timeout,
  // which beats a delayed zone.
  always_comb begin
    keyOk        = KEY_VALID && (KEY_CODE == KEY_OK);
    keyNeg       = KEY_VALID && (KEY_CODE == KEY_OKNEG);
    keyErr       = KEY_VALID && (KEY_CODE == KEY_ERROR);
    instantTrip  = |(sync2_q & ~DELAY_MASK);
    delayedTrip  = |(sync2_q & DELAY_MASK);
    timedOut     = timerExpire || timerZero;
    strikeLimit  = keyErr && (({1'b0, strikes_q} + 4'd1) >= {1'b0, STRIKE_MAX});

    state_d      = state_q;
    strikes_d    = strikes_q;
    zoneLatch_d  = zoneLatch_q;
    timerLoad    = 1'b0;
    timerLoadVal = EXIT_LOAD;

    if (keyOk || keyNeg) begin
      strikes_d = '0;
    end

    if ((state_q == ARMADO) || (state_q == ESPERA) || (state_q == ALARMA)) begin
      zoneLatch_d = zoneLatch_q | sync2_q;
    end

    if (((state_q == ARMADO) || (state_q == ESPERA)) && keyErr) begin
      strikes_d = (strikes_q >= STRIKE_MAX) ? STRIKE_MAX : strikes_q + 3'd1;
    end

    case (state_q)
      INACTIVO: begin
        if (keyOk) begin
          state_d      = SALIDA;
          timerLoad    = 1'b1;
          timerLoadVal = EXIT_LOAD;
          zoneLatch_d  = '0;
        end
      end
      SALIDA: begin
        if (keyNeg) begin
          state_d = INACTIVO;
        end else if (timedOut) begin
          state_d = ARMADO;
        end
      end
      ARMADO: begin
        if (keyNeg) begin
          state_d = INACTIVO;
        end else if (strikeLimit || instantTrip) begin
          state_d = ALARMA;
        end else if (delayedTrip) begin
          state_d      = ESPERA;
          timerLoad    = 1'b1;
          timerLoadVal = ENTRY_LOAD;
        end
      end
      ESPERA: begin
        if (keyOk) begin
          state_d = INACTIVO;
        end else if (strikeLimit || instantTrip || timedOut) begin
          state_d = ALARMA;
        end
      end
      ALARMA: begin
        if (keyOk) begin
          state_d = INACTIVO;
        end
      end
      default: begin
        state_d = INACTIVO;
      end
    endcase

    if (state_d == INACTIVO) begin
      strikes_d = '0;
    end

    status_d = {zoneLatch_d, (state_d == ALARMA), (state_d != INACTIVO)};
  end

  // Main FSM register with all outputs registered alongside the state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= INACTIVO;
      strikes_q   <= '0;
      zoneLatch_q <= '0;
      siren_q     <= 1'b0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      strikes_q   <= strikes_d;
      zoneLatch_q <= zoneLatch_d;
      siren_q     <= (state_d == ALARMA);
      status_q    <= status_d;
    end
  end

  assign STATE_OUT  = state_q;
  assign SIREN_OUT  = siren_q;
  assign ZONE_LATCH = zoneLatch_q;
  assign STATUS_MSG = status_q;

endmodule

// File: tb/tb_alarm_zone_controller.sv
// Scoreboard bench for alarm_zone_controller: directed scenarios plus a randomized run,
// every cycle checked against a tick-timeline reference model.
module tb_alarm_zone_controller;
  import alarm_pkg::*;

  localparam int         NZ    = 4;
  localparam logic [3:0] DMASK = 4'b0010;
  localparam int         EXIT  = 3;
  localparam int         ENTRY = 5;
  localparam int         STR   = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       TICK_EN = 1'b0;
  logic [3:0] SENSOR_IN = '0;
  logic       KEY_VALID = 1'b0;
  logic [1:0] KEY_CODE = NO_KEY;
  logic [2:0] STATE_OUT;
  logic       SIREN_OUT;
  logic [3:0] ZONE_LATCH;
  logic [5:0] STATUS_MSG;

  alarm_zone_controller #(
    .N_ZONES    (NZ),
    .DELAY_MASK (DMASK),
    .EXIT_TICKS (EXIT),
    .ENTRY_TICKS(ENTRY),
    .CNT_W      (18),
    .STRIKES    (STR)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .TICK_EN   (TICK_EN),
    .SENSOR_IN (SENSOR_IN),
    .KEY_VALID (KEY_VALID),
    .KEY_CODE  (KEY_CODE),
    .STATE_OUT (STATE_OUT),
    .SIREN_OUT (SIREN_OUT),
    .ZONE_LATCH(ZONE_LATCH),
    .STATUS_MSG(STATUS_MSG)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0] st;
    logic       siren;
    logic [3:0] latch;
    logic [5:0] status;
  } expect_t;

  expect_t expQ[$];
  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference model: state name, strike tally, latched zones, and a tick timeline
  // where each delay is a deadline on the running tick count.
  alarm_state_e mState;
  int           mStrikes;
  logic [3:0]   mLatch;
  int           mTickTotal;
  int           mDeadline;
  logic [3:0]   syncLine[$];

  function automatic void modelReset();
    mState     = INACTIVO;
    mStrikes   = 0;
    mLatch     = '0;
    mTickTotal = 0;
    mDeadline  = 0;
    syncLine   = {4'b0000, 4'b0000};
  endfunction

  function automatic void modelStep(input logic [3:0] sens, input logic kv,
                                    input logic [1:0] kc, input logic tick);
    logic [3:0]   seen;
    logic         isOk, isNeg, isErr, instant, delayed, alarmHit;
    alarm_state_e nxt;
    expect_t      e;
    seen = syncLine.pop_front();
    syncLine.push_back(sens);
    isOk  = kv && (kc == KEY_OK);
    isNeg = kv && (kc == KEY_OKNEG);
    isErr = kv && (kc == KEY_ERROR);
    instant = (seen & ~DMASK) != 4'b0000;
    delayed = (seen & DMASK) != 4'b0000;
    if (tick) mTickTotal++;
    if (mState == ARMADO || mState == ESPERA || mState == ALARMA) mLatch = mLatch | seen;
    if (isErr && (mState == ARMADO || mState == ESPERA))
      mStrikes = (mStrikes + 1 > STR) ? STR : mStrikes + 1;
    if (isOk || isNeg) mStrikes = 0;
    alarmHit = isErr && (mStrikes >= STR);
    nxt = mState;
    case (mState)
      INACTIVO: if (isOk) begin
        nxt = SALIDA; mDeadline = mTickTotal + EXIT; mLatch = '0;
      end
      SALIDA: begin
        if (isNeg) nxt = INACTIVO;
        else if (mTickTotal >= mDeadline) nxt = ARMADO;
      end
      ARMADO: begin
        if (isNeg) nxt = INACTIVO;
        else if (alarmHit || instant) nxt = ALARMA;
        else if (delayed) begin nxt = ESPERA; mDeadline = mTickTotal + ENTRY; end
      end
      ESPERA: begin
        if (isOk) nxt = INACTIVO;
        else if (alarmHit || instant || mTickTotal >= mDeadline) nxt = ALARMA;
      end
      default: if (isOk) nxt = INACTIVO;
    endcase
    if (nxt == INACTIVO) mStrikes = 0;
    mState   = nxt;
    e.st     = nxt;
    e.siren  = (nxt == ALARMA);
    e.latch  = mLatch;
    e.status = {mLatch, (nxt == ALARMA), (nxt != INACTIVO)};
    expQ.push_back(e);
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cycle, act, exp);
    end
  endtask

  // Drive one cycle of inputs, predict the result of the coming edge, then step.
  task automatic applyStimulus(input logic [3:0] sens, input logic kv,
                               input logic [1:0] kc, input logic tick);
    SENSOR_IN = sens;
    KEY_VALID = kv;
    KEY_CODE  = kc;
    TICK_EN   = tick;
    modelStep(sens, kv, kc, tick);
    @(posedge CLK);
    #2;
  endtask

  task automatic idle(input int n, input logic [3:0] sens);
    for (int i = 0; i < n; i++) applyStimulus(sens, 1'b0, NO_KEY, 1'b1);
  endtask

  task automatic key(input logic [1:0] kc, input logic [3:0] sens);
    applyStimulus(sens, 1'b1, kc, 1'b1);
  endtask

  task automatic arm();
    key(KEY_OK, 4'b0000);
    idle(EXIT, 4'b0000);
  endtask

  task automatic checkState(input string name, input alarm_state_e s);
    checkOutput(name, 8'(STATE_OUT), 8'(s));
  endtask

  // Monitor: one cycle after each edge, pop the prediction for that edge and compare.
  initial begin
    expect_t e;
    forever begin
      @(posedge CLK);
      cycle++;
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("sb_state",  8'(STATE_OUT),  8'(e.st));
        checkOutput("sb_siren",  8'(SIREN_OUT),  8'(e.siren));
        checkOutput("sb_latch",  8'(ZONE_LATCH), 8'(e.latch));
        checkOutput("sb_status", 8'(STATUS_MSG), 8'(e.status));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0] curSens;
    logic [1:0] kc;
    logic       kv, tick;
    modelReset();
    repeat (2) @(posedge CLK);
    #2;
    checkState("rst_state", INACTIVO);
    checkOutput("rst_siren", 8'(SIREN_OUT), 8'd0);
    checkOutput("rst_latch", 8'(ZONE_LATCH), 8'd0);
    checkOutput("rst_status", 8'(STATUS_MSG), 8'd0);
    RST = 1'b0;

    // Arming: exit delay lasts exactly EXIT ticks.
    key(KEY_OK, 4'b0000);
    checkState("arm_salida", SALIDA);
    idle(EXIT - 1, 4'b0000);
    checkState("arm_still_salida", SALIDA);
    idle(1, 4'b0000);
    checkState("arm_armado", ARMADO);
    checkOutput("arm_status", 8'(STATUS_MSG), 8'b0000_0001);

    // Entry delay on the door zone, then disarm from ALARMA.
    idle(2, 4'b0010);
    checkState("entry_not_yet", ARMADO);
    idle(1, 4'b0010);
    checkState("entry_espera", ESPERA);
    idle(ENTRY - 1, 4'b0010);
    checkState("entry_still_espera", ESPERA);
    idle(1, 4'b0010);
    checkState("entry_alarma", ALARMA);
    checkOutput("entry_siren", 8'(SIREN_OUT), 8'd1);
    checkOutput("entry_latch", 8'(ZONE_LATCH), 8'b0000_0010);
    key(KEY_OK, 4'b0000);
    checkState("entry_disarm", INACTIVO);
    checkOutput("entry_siren_off", 8'(SIREN_OUT), 8'd0);
    checkOutput("entry_latch_kept", 8'(ZONE_LATCH), 8'b0000_0010);

    // Instant window zone while armed.
    arm();
    checkOutput("rearm_latch_clear", 8'(ZONE_LATCH), 8'd0);
    idle(3, 4'b0001);
    checkState("instant_alarma", ALARMA);
    checkOutput("instant_status", 8'(STATUS_MSG), 8'b0000_0111);
    key(KEY_OK, 4'b0000);
    idle(2, 4'b0000);

    // Instant zone during the entry delay cuts it short.
    arm();
    idle(3, 4'b0010);
    checkState("esp_inst_espera", ESPERA);
    idle(2, 4'b0011);
    checkState("esp_inst_wait", ESPERA);
    idle(1, 4'b0011);
    checkState("esp_inst_alarma", ALARMA);
    key(KEY_OK, 4'b0000);
    idle(2, 4'b0000);

    // Strike limit, strikes cleared by disarm, strikes cleared by KEY_OK.
    arm();
    key(KEY_ERROR, 4'b0000);
    key(KEY_ERROR, 4'b0000);
    checkState("strike_two", ARMADO);
    key(KEY_ERROR, 4'b0000);
    checkState("strike_three", ALARMA);
    key(KEY_OK, 4'b0000);
    arm();
    key(KEY_ERROR, 4'b0000);
    key(KEY_ERROR, 4'b0000);
    key(KEY_OKNEG, 4'b0000);
    checkState("strike_disarm", INACTIVO);
    arm();
    key(KEY_ERROR, 4'b0000);
    key(KEY_ERROR, 4'b0000);
    key(KEY_OK, 4'b0000);
    key(KEY_ERROR, 4'b0000);
    checkState("strike_cleared", ARMADO);
    key(KEY_OKNEG, 4'b0000);

    // Disarm and instant trip on the same edge: disarm wins.
    arm();
    idle(2, 4'b0001);
    key(KEY_OKNEG, 4'b0001);
    checkState("collide_state", INACTIVO);
    checkOutput("collide_siren", 8'(SIREN_OUT), 8'd0);
    idle(2, 4'b0000);

    // Asynchronous reset in the middle of the entry delay.
    arm();
    idle(3, 4'b0010);
    idle(3, 4'b0010);
    checkState("pre_rst_espera", ESPERA);
    SENSOR_IN = '0;
    KEY_VALID = 1'b0;
    #1 RST = 1'b1;
    #1;
    checkState("mid_rst_state", INACTIVO);
    checkOutput("mid_rst_siren", 8'(SIREN_OUT), 8'd0);
    checkOutput("mid_rst_latch", 8'(ZONE_LATCH), 8'd0);
    checkOutput("mid_rst_status", 8'(STATUS_MSG), 8'd0);
    @(posedge CLK);
    #2;
    RST = 1'b0;
    modelReset();

    // Randomized run against the model.
    curSens = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0)
        curSens = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      kv   = ($urandom_range(0, 99) < 15);
      kc   = 2'($urandom_range(0, 3));
      if (!kv && $urandom_range(0, 1) == 0) kc = NO_KEY;
      tick = ($urandom_range(0, 99) < 70);
      applyStimulus(curSens, kv, kc, tick);
    end

    idle(1, 4'b0000);
    checkOutput("queue_drained", 8'(expQ.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
